alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, 4: cycles operands are held on the ALU before a MUL result is captured (1..63).
REQ-002 Parameter DIV_CYCLES, 32: same for DIV (1..63).
REQ-003 Parameter SHIFT_CYCLES, 1: same for shift (1..63).
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 clear  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 op  in  5  operation code: 5'b00010 MUL, 5'b00011 DIV, 5'b00100 shift.
REQ-008 a, b  in  32 each  operands.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  error flag for the completed operation; valid while done=1.
REQ-012 hi, lo  out  32 each  result registers: hi = result[63:32], lo = result[31:0].
REQ-013 alu_A, alu_B  out  32 each  operands driven to the ALU.
REQ-014 alu_op  out  5  op code driven to the ALU.
REQ-015 alu_C  in  64  ALU result; DIV packs remainder in [63:32] and quotient in [31:0].

Function
REQ-016 FSM states: IDLE, EXEC, DONE.
REQ-017 IDLE with start=1: latch a, b and op into operand registers; load cnt with L-1; go to EXEC. L is selected by op.
REQ-018 IDLE with start=1 and an unsupported op: go directly to DONE with err=1; hi/lo unchanged.
REQ-019 EXEC: alu_A, alu_B and alu_op hold the latched values and stay stable.
REQ-020 EXEC with cnt!=0: decrement cnt.
REQ-021 EXEC with cnt==0: hi <= alu_C[63:32], lo <= alu_C[31:0], err <= 0, go to DONE.
REQ-022 DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
REQ-023 Latency: done goes high L rising edges after the edge that sampled start. The next start is accepted no earlier than L+1 edges after the previous one.
REQ-024 start while busy=1 (EXEC or DONE) is ignored, with no queuing.
REQ-025 Operand, a, b and op changes after acceptance have no effect on the operation in flight.
REQ-026 hi/lo change only at the capture edge, and hold their values across idle periods.
REQ-027 cnt is 6 bits; L=1 means a single EXEC cycle.
REQ-028 In IDLE, alu_A, alu_B and alu_op show the last latched values.

Reset
REQ-029 clear=1 at any edge, including mid-EXEC: state=IDLE, cnt=0, operand registers=0, hi=0, lo=0, busy=0, done=0, err=0.
REQ-030 Reset aborts an in-flight operation with no done pulse; start in the same cycle as clear is ignored.

Configuration
REQ-031 Macro ALU_SEQ_DIVZERO_EN defined: DIV with b==0 skips EXEC, goes to DONE the next edge with err=1, hi=0, lo=0.
REQ-032 Macro ALU_SEQ_DIVZERO_EN undefined: DIV with b==0 runs DIV_CYCLES like any other DIV; hi/lo take whatever alu_C provides; err=0.

Structure
REQ-033 Shared package alu_pkg holds: op-code constants (ALU_OP_MUL, ALU_OP_DIV, ALU_OP_SHIFT), the FSM state enum, and the default cycle counts.
REQ-034 One sub-module, alu_op_latency (combinational op -> L and supported flag), is natural. The ALU itself is instantiated outside this block.

Verification
REQ-035 MUL a=6, b=7, MUL_CYCLES=4 -> busy for 5 cycles; done 4 edges after start; hi=0, lo=42, err=0.
REQ-036 DIV a=100, b=7, DIV_CYCLES=32 -> done at edge 32; hi=2, lo=14, err=0.
REQ-037 DIV b=0 with ALU_SEQ_DIVZERO_EN -> done at edge 1; err=1, hi=lo=0. Without the macro -> done at edge 32, err=0.
REQ-038 start held high during an in-flight MUL, with a different op -> exactly one done; result is that of the first op.
REQ-039 clear at edge 2 of a DIV -> no done pulse; hi=lo=0. A new MUL 3*3 started after clear -> lo=9.
REQ-040 op=5'b11111 -> done at edge 1 with err=1; hi/lo unchanged from the prior result.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and default cycle counts for alu_sequencer
package alu_pkg;

  localparam logic [4:0] ALU_OP_MUL   = 5'b00010;
  localparam logic [4:0] ALU_OP_DIV   = 5'b00011;
  localparam logic [4:0] ALU_OP_SHIFT = 5'b00100;

  localparam int DEF_MUL_CYCLES   = 4;
  localparam int DEF_DIV_CYCLES   = 32;
  localparam int DEF_SHIFT_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Reason an operation will finish without capturing the ALU result.
  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_BADOP,
    FLT_DIVZ
  } fault_e;

endpackage

// File: rtl/alu_op_latency.sv
// rtl/alu_op_latency.sv - combinational op code to hold latency and supported flag
module alu_op_latency
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES   = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES   = DEF_DIV_CYCLES,
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES
) (
  input  logic [4:0] op_i,
  output logic [5:0] lat_o,
  output logic       supported_o
);

  always_comb begin
    lat_o       = 6'd1;
    supported_o = 1'b0;
    case (op_i)
      ALU_OP_MUL:   begin lat_o = 6'(MUL_CYCLES);   supported_o = 1'b1; end
      ALU_OP_DIV:   begin lat_o = 6'(DIV_CYCLES);   supported_o = 1'b1; end
      ALU_OP_SHIFT: begin lat_o = 6'(SHIFT_CYCLES); supported_o = 1'b1; end
      default:      begin lat_o = 6'd1;             supported_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - holds operands on an external ALU for a per-op cycle count, then captures hi/lo
// Optional macro ALU_SEQ_DIVZERO_EN: fast error completion for DIV with b==0.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES   = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES   = DEF_DIV_CYCLES,
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_C
);

  state_e      state_q, state_d;
  fault_e      fault_q, fault_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  op_q, op_d;
  logic        err_q, err_d;
  logic [5:0]  lat;
  logic        supported;

  alu_op_latency #(
    .MUL_CYCLES  (MUL_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .SHIFT_CYCLES(SHIFT_CYCLES)
  ) u_lat (
    .op_i       (op),
    .lat_o      (lat),
    .supported_o(supported)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = ST_EXEC;
          // Faulted ops spend one cycle in EXEC so done still lands one edge after start.
          if (!supported) begin
            fault_d = FLT_BADOP;
            cnt_d   = 6'd0;
          end
`ifdef ALU_SEQ_DIVZERO_EN
          else if (op == ALU_OP_DIV && b == 32'd0) begin
            fault_d = FLT_DIVZ;
            cnt_d   = 6'd0;
          end
`endif
          else begin
            fault_d = FLT_NONE;
            cnt_d   = lat - 6'd1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = ST_DONE;
          case (fault_q)
            FLT_BADOP: err_d = 1'b1;
            FLT_DIVZ: begin
              err_d = 1'b1;
              hi_d  = 32'd0;
              lo_d  = 32'd0;
            end
            default: begin
              err_d = 1'b0;
              hi_d  = alu_C[63:32];
              lo_d  = alu_C[31:0];
            end
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      fault_q <= FLT_NONE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign alu_A  = a_q;
  assign alu_B  = b_q;
  assign alu_op = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_DIV   = 5'b00011;
  localparam logic [4:0] OP_SHIFT = 5'b00100;
  localparam logic [4:0] OP_BAD   = 5'b11111;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done, err;
  logic [31:0] hi, lo, alu_A, alu_B;
  logic [4:0]  alu_op;
  logic [63:0] alu_C;

  int checks = 0;
  int errors = 0;
  int edges, busy_n, ndone;

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .hi    (hi),
    .lo    (lo),
    .alu_A (alu_A),
    .alu_B (alu_B),
    .alu_op(alu_op),
    .alu_C (alu_C)
  );

  // Reference ALU; DIV packs remainder high, quotient low.
  always_comb begin
    alu_C = 64'd0;
    case (alu_op)
      OP_MUL:   alu_C = {32'd0, alu_A} * {32'd0, alu_B};
      OP_DIV:   alu_C = (alu_B == 32'd0) ? {alu_A, 32'hFFFF_FFFF}
                                         : {alu_A % alu_B, alu_A / alu_B};
      OP_SHIFT: alu_C = {32'd0, alu_A} << alu_B[5:0];
      default:  alu_C = 64'd0;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Accept edge, then scramble inputs to show the in-flight op ignores them.
  task automatic go(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 5'd0;
  endtask

  task automatic run_to_done(output int e, output int bn);
    e  = 0;
    bn = busy ? 1 : 0;
    while (!done && e < 200) begin
      tick();
      e++;
      if (busy) bn++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; op = 5'd0; a = 32'd0; b = 32'd0;
    tick();
    tick();
    clear = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_alu_A", {32'd0, alu_A}, 64'd0);
    chk("rst_alu_op", {59'd0, alu_op}, 64'd0);

    // start coincident with clear is ignored
    clear = 1'b1; start = 1'b1; op = OP_MUL; a = 32'd6; b = 32'd7;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("start_in_clear_busy", {63'd0, busy}, 64'd0);
    chk("start_in_clear_alu_A", {32'd0, alu_A}, 64'd0);

    // MUL 6*7
    go(OP_MUL, 32'd6, 32'd7);
    run_to_done(edges, busy_n);
    chk("mul_edges", 64'(edges), 64'd4);
    chk("mul_busy_cycles", 64'(busy_n), 64'd5);
    chk("mul_hi", {32'd0, hi}, 64'd0);
    chk("mul_lo", {32'd0, lo}, 64'd42);
    chk("mul_err", {63'd0, err}, 64'd0);
    tick();
    chk("mul_done_one_cycle", {63'd0, done}, 64'd0);
    chk("mul_idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_alu_A_held", {32'd0, alu_A}, 64'd6);
    chk("idle_alu_B_held", {32'd0, alu_B}, 64'd7);
    chk("idle_lo_held", {32'd0, lo}, 64'd42);

    // DIV 100/7
    go(OP_DIV, 32'd100, 32'd7);
    run_to_done(edges, busy_n);
    chk("div_edges", 64'(edges), 64'd32);
    chk("div_hi", {32'd0, hi}, 64'd2);
    chk("div_lo", {32'd0, lo}, 64'd14);
    chk("div_err", {63'd0, err}, 64'd0);
    tick();

    // DIV by zero
    go(OP_DIV, 32'd55, 32'd0);
    run_to_done(edges, busy_n);
`ifdef ALU_SEQ_DIVZERO_EN
    chk("divz_edges", 64'(edges), 64'd1);
    chk("divz_err", {63'd0, err}, 64'd1);
    chk("divz_hi", {32'd0, hi}, 64'd0);
    chk("divz_lo", {32'd0, lo}, 64'd0);
`else
    chk("divz_edges", 64'(edges), 64'd32);
    chk("divz_err", {63'd0, err}, 64'd0);
    chk("divz_hi", {32'd0, hi}, 64'd55);
    chk("divz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
`endif
    tick();

    // start held high across an in-flight MUL while op/operands change
    op = OP_MUL; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    op = OP_DIV; a = 32'd9; b = 32'd3;
    edges = 0;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    ndone = done ? 1 : 0;
    start = 1'b0;
    repeat (10) begin
      tick();
      if (done) ndone++;
    end
    chk("held_start_edges", 64'(edges), 64'd4);
    chk("held_start_ndone", 64'(ndone), 64'd1);
    chk("held_start_lo", {32'd0, lo}, 64'd25);
    chk("held_start_hi", {32'd0, hi}, 64'd0);

    // clear at edge 2 of a DIV
    go(OP_DIV, 32'd100, 32'd7);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    go(OP_MUL, 32'd3, 32'd3);
    run_to_done(edges, busy_n);
    chk("mul3_edges", 64'(edges), 64'd4);
    chk("mul3_lo", {32'd0, lo}, 64'd9);
    tick();

    // single-cycle shift crossing into hi
    go(OP_SHIFT, 32'h8000_0001, 32'd1);
    run_to_done(edges, busy_n);
    chk("shift_edges", 64'(edges), 64'd1);
    chk("shift_hi", {32'd0, hi}, 64'd1);
    chk("shift_lo", {32'd0, lo}, 64'd2);
    chk("shift_err", {63'd0, err}, 64'd0);
    tick();

    // unsupported op leaves hi/lo untouched
    go(OP_BAD, 32'd1, 32'd2);
    run_to_done(edges, busy_n);
    chk("badop_edges", 64'(edges), 64'd1);
    chk("badop_err", {63'd0, err}, 64'd1);
    chk("badop_hi", {32'd0, hi}, 64'd1);
    chk("badop_lo", {32'd0, lo}, 64'd2);
    tick();
    chk("badop_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
